// File: rtl/rvtu_cache.sv
// rvtu_cache: direct-mapped, write-through, no-write-allocate L1 cache for the rvtu core
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   c_maddr/c_mrd/c_mwr/c_mwdata  core-side request (held until c_mresp)
//   c_mresp/c_mrdata          registered one-cycle completion pulse and read data
//   m_addr/m_rd/m_wr/m_wdata  memory-side word request (held until m_resp)
//   m_resp/m_rdata            memory completion pulse and read data
module rvtu_cache #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] c_maddr,
    input  logic        c_mrd,
    input  logic [3:0]  c_mwr,
    input  logic [31:0] c_mwdata,
    output logic        c_mresp,
    output logic [31:0] c_mrdata,
    output logic [31:0] m_addr,
    output logic        m_rd,
    output logic [3:0]  m_wr,
    output logic [31:0] m_wdata,
    input  logic        m_resp,
    input  logic [31:0] m_rdata
);
    localparam int TAG_BITS  = 30 - INDEX_BITS - OFFSET_BITS;
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int LINE_BITS = INDEX_BITS + OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;
    state_t state, state_nxt;

    logic [SETS-1:0]            valid;
    logic [TAG_BITS-1:0]        tags [SETS];
    logic [31:0]                data [1 << LINE_BITS];
    logic [29:0]                req;
    logic [OFFSET_BITS-1:0]     cnt, cnt_nxt;
    logic                       w_hit;
    logic [TAG_BITS-1:0]        c_tag, r_tag;
    logic [INDEX_BITS-1:0]      c_idx, r_idx;
    logic [LINE_BITS-1:0]       c_line, r_line;
    logic [OFFSET_BITS-1:0]     r_off;
    logic                       hit, accept, acc_rd, acc_wr, beat, last, wr_done;
    logic                       unused;

    assign unused = ^c_maddr[1:0];
    assign c_tag  = c_maddr[31 -: TAG_BITS];
    assign c_idx  = c_maddr[LINE_BITS+1 : OFFSET_BITS+2];
    assign c_line = c_maddr[LINE_BITS+1 : 2];
    assign r_tag  = req[29 -: TAG_BITS];
    assign r_idx  = req[LINE_BITS-1 : OFFSET_BITS];
    assign r_line = req[LINE_BITS-1 : 0];
    assign r_off  = req[OFFSET_BITS-1 : 0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = acc_wr ? WRITE : (acc_rd && !hit) ? REFILL : IDLE;
            REFILL:  state_nxt = last ? IDLE : REFILL;
            WRITE:   state_nxt = wr_done ? IDLE : WRITE;
            default: state_nxt = IDLE;
        endcase
    end

    // The c_mresp cycle is excluded from acceptance: the arbiter switches owner then.
    always_comb begin
        hit     = valid[c_idx] && tags[c_idx] == c_tag;
        accept  = state == IDLE && !c_mresp && (c_mwr != 4'b0 || c_mrd);
        acc_wr  = accept && c_mwr != 4'b0;
        acc_rd  = accept && c_mwr == 4'b0;
        beat    = state == REFILL && m_resp;
        last    = beat && cnt == '1;
        wr_done = state == WRITE && m_resp;
        cnt_nxt = cnt + OFFSET_BITS'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= '0;
            c_mresp  <= 1'b0;
            c_mrdata <= '0;
            m_addr   <= '0;
            m_rd     <= 1'b0;
            m_wr     <= '0;
            m_wdata  <= '0;
            req      <= '0;
            cnt      <= '0;
            w_hit    <= 1'b0;
        end else begin
            c_mresp <= last || wr_done || (acc_rd && hit);
            if (acc_rd && hit) c_mrdata <= data[c_line];
            // The final beat is not yet in the array, so forward it directly.
            if (last) c_mrdata <= (r_off == '1) ? m_rdata : data[r_line];
            if (acc_rd && !hit) begin
                req    <= c_maddr[31:2];
                cnt    <= '0;
                m_rd   <= 1'b1;
                m_addr <= {c_maddr[31:OFFSET_BITS+2], {OFFSET_BITS{1'b0}}, 2'b00};
            end
            if (beat && !last) begin
                cnt    <= cnt_nxt;
                m_addr <= {req[29:OFFSET_BITS], cnt_nxt, 2'b00};
            end
            if (last) begin
                valid[r_idx] <= 1'b1;
                m_rd         <= 1'b0;
            end
            if (acc_wr) begin
                req     <= c_maddr[31:2];
                w_hit   <= hit;
                m_addr  <= {c_maddr[31:2], 2'b00};
                m_wr    <= c_mwr;
                m_wdata <= c_mwdata;
            end
            if (wr_done) m_wr <= '0;
        end
    end

    // Line storage needs no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (beat) data[{r_idx, cnt}] <= m_rdata;
        if (last) tags[r_idx] <= r_tag;
        if (wr_done && w_hit)
            for (int b = 0; b < 4; b++)
                if (m_wr[b]) data[r_line][8*b +: 8] <= m_wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_rvtu_cache.sv
// tb_rvtu_cache: scoreboard bench for rvtu_cache with a line-occupancy reference model
module tb_rvtu_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] c_maddr, c_mwdata, c_mrdata, m_addr, m_wdata, m_rdata;
    logic        c_mrd, c_mresp, m_rd, m_resp;
    logic [3:0]  c_mwr, m_wr;

    typedef struct packed {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         mem_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] mem [logic [31:0]];
    logic        mv [16];
    logic [23:0] mt [16];
    logic [31:0] last_rd;
    int          checks = 0, passes = 0, beats = 0;
    logic        rand_lat = 1'b0;
    logic        prev = 1'b0;

    always #5 clk = ~clk;

    rvtu_cache dut (
        .clk(clk), .rst(rst),
        .c_maddr(c_maddr), .c_mrd(c_mrd), .c_mwr(c_mwr), .c_mwdata(c_mwdata),
        .c_mresp(c_mresp), .c_mrdata(c_mrdata),
        .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wdata(m_wdata),
        .m_resp(m_resp), .m_rdata(m_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference: which line each set holds; memory is the single source of data truth.
    task automatic model_issue(input logic [31:0] a, input logic [3:0] wr, input logic [31:0] wd);
        int set = int'(a[7:4]);
        op_t op;
        if (wr != 4'b0) begin
            op = '{1'b1, wr, {a[31:2], 2'b00}, wd};
            mem_q.push_back(op);
            exp_q.push_back(last_rd);
        end else begin
            if (!(mv[set] && mt[set] == a[31:8])) begin
                for (int k = 0; k < 4; k++) begin
                    op = '{1'b0, 4'b0, {a[31:4], 4'b0} + 32'(4 * k), 32'b0};
                    mem_q.push_back(op);
                end
                mv[set] = 1'b1;
                mt[set] = a[31:8];
            end
            last_rd = memval({a[31:2], 2'b00});
            exp_q.push_back(last_rd);
        end
    endtask

    task automatic do_req(input logic [31:0] a, input logic rd, input logic [3:0] wr,
                          input logic [31:0] wd, output int n);
        model_issue(a, wr, wd);
        c_maddr = a; c_mrd = rd; c_mwr = wr; c_mwdata = wd;
        n = 0;
        do begin
            @(posedge clk); n++;
            @(negedge clk);
        end while (!c_mresp && n < 300);
        if (!c_mresp) begin
            checks++;
            $display("FAIL req_timeout: addr %h got no c_mresp expected one within 300 cycles", a);
        end
    endtask

    task automatic idle();
        c_mrd = 1'b0; c_mwr = 4'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Memory responder: one m_resp per held request, latency fixed or random.
    initial begin
        int w = 0, lat = 2;
        op_t op;
        logic [31:0] wa;
        m_resp = 1'b0; m_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (rst || m_resp) begin
                m_resp = 1'b0; w = 0;
            end else if (m_rd || m_wr != 4'b0) begin
                if (w < lat) w++;
                else begin
                    w = 0;
                    lat = rand_lat ? int'($urandom_range(0, 3)) : 2;
                    beats++;
                    if (mem_q.size() == 0) begin
                        checks++;
                        $display("FAIL mem_unexpected: got addr %h rd %b wr %b expected no transaction", m_addr, m_rd, m_wr);
                    end else begin
                        op = mem_q.pop_front();
                        chk("mem_addr", m_addr, op.addr);
                        chk("mem_cmd", {27'b0, m_rd, m_wr}, {27'b0, !op.wr, op.strb});
                        if (op.wr) chk("mem_wdata", m_wdata, op.data);
                    end
                    wa = {m_addr[31:2], 2'b00};
                    m_rdata = memval(wa);
                    if (m_wr != 4'b0) mem[wa] = merge(memval(wa), m_wdata, m_wr);
                    m_resp = 1'b1;
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on every c_mresp.
    always @(negedge clk) begin
        if (rst) prev = 1'b0;
        else begin
            if (c_mresp) begin
                chk("resp_back_to_back", {31'b0, prev}, 32'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL resp_unexpected: got c_mresp with %h expected none", c_mrdata);
                end else chk("rdata", c_mrdata, exp_q.pop_front());
            end
            prev = c_mresp;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n, b0, t;
        logic [31:0] a;
        rst = 1'b1; c_maddr = '0; c_mrd = 1'b0; c_mwr = '0; c_mwdata = '0; last_rd = '0;
        for (int i = 0; i < 16; i++) begin mv[i] = 1'b0; mt[i] = '0; end
        for (int k = 0; k < 4; k++) mem[32'h1000 + 32'(4 * k)] = 32'hA0 + 32'(k);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c_mresp", {31'b0, c_mresp}, 0);
        chk("rst_c_mrdata", c_mrdata, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_cmd", {27'b0, m_rd, m_wr}, 0);
        rst = 1'b0;

        idle(); b0 = beats;
        do_req(32'h1004, 1'b1, 4'b0, 0, n);
        chk("cold_beats", 32'(beats - b0), 4);
        chk("cold_rdata", c_mrdata, 32'hA1);
        chk("miss_latency_ge5", {31'b0, n >= 5}, 1);

        idle(); b0 = beats;
        do_req(32'h1008, 1'b1, 4'b0, 0, n);
        chk("hit_latency", 32'(n), 1);
        chk("hit_no_mem", 32'(beats - b0), 0);

        idle(); b0 = beats;
        do_req(32'h1004, 1'b0, 4'b0011, 32'h1234_5678, n);
        chk("write_beats", 32'(beats - b0), 1);
        idle();
        do_req(32'h1004, 1'b1, 4'b0, 0, n);
        chk("merged_latency", 32'(n), 1);
        chk("merged_rdata", c_mrdata, 32'h0000_5678);

        idle(); b0 = beats;
        do_req(32'h2000, 1'b0, 4'b1111, 32'hCAFE_F00D, n);
        chk("wmiss_beats", 32'(beats - b0), 1);
        idle(); b0 = beats;
        do_req(32'h2000, 1'b1, 4'b0, 0, n);
        chk("wmiss_refill_beats", 32'(beats - b0), 4);
        chk("wmiss_rdata", c_mrdata, 32'hCAFE_F00D);

        idle(); b0 = beats;
        model_issue(32'h1004, 4'b0, 0);
        c_maddr = 32'h1004; c_mrd = 1'b1;
        t = 0;
        while (beats - b0 < 2 && t < 200) begin @(negedge clk); t++; end
        chk("abort_two_beats", 32'(beats - b0), 2);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_c_mresp", {31'b0, c_mresp}, 0);
        chk("arst_c_mrdata", c_mrdata, 0);
        chk("arst_m_addr", m_addr, 0);
        chk("arst_m_cmd", {27'b0, m_rd, m_wr}, 0);
        chk("arst_m_wdata", m_wdata, 0);
        exp_q.delete(); mem_q.delete(); last_rd = '0;
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
        c_mrd = 1'b0; c_maddr = '0;
        repeat (3) begin @(negedge clk); chk("arst_no_resp", {31'b0, c_mresp}, 0); end
        rst = 1'b0;
        idle(); b0 = beats;
        do_req(32'h1004, 1'b1, 4'b0, 0, n);
        chk("post_rst_beats", 32'(beats - b0), 4);
        chk("post_rst_rdata", c_mrdata, 32'h0000_5678);

        rand_lat = 1'b1;
        for (int i = 0; i < 160; i++) begin
            if (i % 7 == 0) idle();
            if (i % 2 == 0) begin
                a = 32'h4000 + 32'($urandom_range(0, 127)) * 4;
                do_req(a, 1'b1, 4'b0, 0, n);
            end else begin
                a = 32'h8000 + 32'($urandom_range(0, 63)) * 4;
                if ($urandom_range(0, 3) == 0) do_req(a, 1'b1, 4'b0, 0, n);
                else do_req(a, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, n);
            end
        end
        idle();
        repeat (10) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("mem_q_drained", 32'(mem_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
